// File: rtl/beehive_noc_msg_pkg.sv
// NoC message definitions shared by every tile: header flit layout and field widths.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif

package beehive_noc_msg;

    localparam int NOC_DATA_W = `NOC_DATA_WIDTH;
    localparam int CHIP_ID_W  = 14;
    localparam int XY_W       = 8;
    localparam int FBITS_W    = 4;
    localparam int MSG_LEN_W  = 22;
    localparam int MSG_TYPE_W = 8;
    localparam int HDR_USED_W = 2 * (CHIP_ID_W + 2 * XY_W + FBITS_W) + MSG_LEN_W + MSG_TYPE_W;
    localparam int HDR_PAD_W  = NOC_DATA_W - HDR_USED_W;

    typedef struct packed {
        logic [CHIP_ID_W-1:0]  dst_chip_id;
        logic [XY_W-1:0]       dst_x;
        logic [XY_W-1:0]       dst_y;
        logic [FBITS_W-1:0]    dst_fbits;
        logic [MSG_LEN_W-1:0]  msg_len;
        logic [MSG_TYPE_W-1:0] msg_type;
        logic [CHIP_ID_W-1:0]  src_chip_id;
        logic [XY_W-1:0]       src_x;
        logic [XY_W-1:0]       src_y;
        logic [FBITS_W-1:0]    src_fbits;
        logic [HDR_PAD_W-1:0]  metadata;
    } noc_hdr_flit;

endpackage

// File: rtl/beehive_udp_msg_pkg.sv
// UDP message definitions: TX metadata flit, TX message type and payload flit-count helper.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif

package beehive_udp_msg;
    import beehive_noc_msg::*;

    localparam logic [MSG_TYPE_W-1:0] UDP_TX_SEGMENT = 8'd40;
    localparam int UDP_META_USED_W = 32 + 32 + 16 + 16 + 16;
    localparam int UDP_META_PAD_W  = NOC_DATA_W - UDP_META_USED_W;
    localparam int NOC_DATA_BYTES  = NOC_DATA_W / 8;

    typedef struct packed {
        logic [31:0]               src_ip;
        logic [31:0]               dst_ip;
        logic [15:0]               src_port;
        logic [15:0]               dst_port;
        logic [15:0]               data_len;
        logic [UDP_META_PAD_W-1:0] padding;
    } udp_tx_metadata_flit;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_HDR   = 2'd1,
        ST_META  = 2'd2,
        ST_DATA  = 2'd3
    } framer_state_e;

    // 17-bit sum keeps 16'hFFFF + (bytes-1) from wrapping
    function automatic logic [16:0] udp_num_data_flits(input logic [15:0] len);
        return ({1'b0, len} + 17'(NOC_DATA_BYTES - 1)) / 17'(NOC_DATA_BYTES);
    endfunction

endpackage

// File: rtl/udp_tx_noc_framer.sv
// Frames one UDP TX request as NoC header flit, metadata flit, then pass-through payload flits.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif

module udp_tx_noc_framer
    import beehive_noc_msg::*;
    import beehive_udp_msg::*;
#(
    parameter int SRC_X = 0,
    parameter int SRC_Y = 0,
    parameter int DST_X = 0,
    parameter int DST_Y = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       src_framer_meta_val,
    input  logic [31:0]                src_framer_meta_src_ip,
    input  logic [31:0]                src_framer_meta_dst_ip,
    input  logic [15:0]                src_framer_meta_src_port,
    input  logic [15:0]                src_framer_meta_dst_port,
    input  logic [15:0]                src_framer_meta_data_len,
    output logic                       framer_src_meta_rdy,
    input  logic                       src_framer_data_val,
    input  logic [`NOC_DATA_WIDTH-1:0] src_framer_data,
    input  logic                       src_framer_data_last,
    output logic                       framer_src_data_rdy,
    output logic                       framer_noc_val,
    output logic [`NOC_DATA_WIDTH-1:0] framer_noc_data,
    input  logic                       noc_framer_rdy,
    output logic                       framer_len_err
);

    localparam int NOC_W = `NOC_DATA_WIDTH;

    generate
        if ($bits(noc_hdr_flit) != NOC_W) begin : g_hdr_width_check
            $fatal(1, "noc_hdr_flit width differs from NOC_DATA_WIDTH");
        end
        if ($bits(udp_tx_metadata_flit) != NOC_W) begin : g_meta_width_check
            $fatal(1, "udp_tx_metadata_flit width differs from NOC_DATA_WIDTH");
        end
    endgenerate

    framer_state_e       state_q;
    framer_state_e       state_d;
    logic [31:0]         src_ip_q;
    logic [31:0]         dst_ip_q;
    logic [15:0]         src_port_q;
    logic [15:0]         dst_port_q;
    logic [15:0]         data_len_q;
    logic [16:0]         flit_cnt_q;
    logic                len_err_q;
    logic                meta_hs_s;
    logic                noc_hs_s;
    logic                cnt_last_s;
    noc_hdr_flit         hdr_flit_s;
    udp_tx_metadata_flit meta_flit_s;

    assign meta_hs_s      = src_framer_meta_val & framer_src_meta_rdy;
    assign noc_hs_s       = framer_noc_val & noc_framer_rdy;
    assign cnt_last_s     = (flit_cnt_q == 17'd1);
    assign framer_len_err = len_err_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request fields, payload flit down-counter and sticky length error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_ip_q   <= 32'd0;
            dst_ip_q   <= 32'd0;
            src_port_q <= 16'd0;
            dst_port_q <= 16'd0;
            data_len_q <= 16'd0;
            flit_cnt_q <= 17'd0;
            len_err_q  <= 1'b0;
        end else begin
            if (meta_hs_s) begin
                src_ip_q   <= src_framer_meta_src_ip;
                dst_ip_q   <= src_framer_meta_dst_ip;
                src_port_q <= src_framer_meta_src_port;
                dst_port_q <= src_framer_meta_dst_port;
                data_len_q <= src_framer_meta_data_len;
                flit_cnt_q <= udp_num_data_flits(src_framer_meta_data_len);
            end else if ((state_q == ST_DATA) && noc_hs_s) begin
                flit_cnt_q <= flit_cnt_q - 17'd1;
            end
            // The count decides framing; a disagreeing last marker is only flagged
            if ((state_q == ST_DATA) && noc_hs_s && (src_framer_data_last != cnt_last_s)) begin
                len_err_q <= 1'b1;
            end
        end
    end

    // Header and metadata flits are built purely from registered fields, so they hold under stall
    always_comb begin
        hdr_flit_s          = '0;
        hdr_flit_s.dst_x    = XY_W'(DST_X);
        hdr_flit_s.dst_y    = XY_W'(DST_Y);
        hdr_flit_s.src_x    = XY_W'(SRC_X);
        hdr_flit_s.src_y    = XY_W'(SRC_Y);
        hdr_flit_s.msg_len  = MSG_LEN_W'(flit_cnt_q) + 22'd1;
        hdr_flit_s.msg_type = UDP_TX_SEGMENT;

        meta_flit_s          = '0;
        meta_flit_s.src_ip   = src_ip_q;
        meta_flit_s.dst_ip   = dst_ip_q;
        meta_flit_s.src_port = src_port_q;
        meta_flit_s.dst_port = dst_port_q;
        meta_flit_s.data_len = data_len_q;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d             = state_q;
        framer_src_meta_rdy = 1'b0;
        framer_src_data_rdy = 1'b0;
        framer_noc_val      = 1'b0;
        framer_noc_data     = '0;
        case (state_q)
            ST_READY: begin
                framer_src_meta_rdy = 1'b1;
                if (src_framer_meta_val) begin
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_HDR: begin
                framer_noc_val  = 1'b1;
                framer_noc_data = hdr_flit_s;
                if (noc_framer_rdy) begin
                    state_d = ST_META;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_META: begin
                framer_noc_val  = 1'b1;
                framer_noc_data = meta_flit_s;
                if (noc_framer_rdy) begin
                    state_d = (data_len_q == 16'd0) ? ST_READY : ST_DATA;
                end else begin
                    state_d = ST_META;
                end
            end
            ST_DATA: begin
                framer_noc_val      = src_framer_data_val;
                framer_noc_data     = src_framer_data;
                framer_src_data_rdy = noc_framer_rdy;
                if (src_framer_data_val && noc_framer_rdy && cnt_last_s) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

endmodule

// File: tb/tb_udp_tx_noc_framer.sv
// Directed bench for udp_tx_noc_framer: hand-computed header/metadata fields and flit counts.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif

module tb_udp_tx_noc_framer;
    import beehive_noc_msg::*;
    import beehive_udp_msg::*;

    localparam int W = `NOC_DATA_WIDTH;

    logic         clk;
    logic         rst_n;
    logic         meta_val;
    logic [31:0]  meta_src_ip;
    logic [31:0]  meta_dst_ip;
    logic [15:0]  meta_src_port;
    logic [15:0]  meta_dst_port;
    logic [15:0]  meta_len;
    logic         meta_rdy;
    logic         data_val;
    logic [W-1:0] data;
    logic         data_last;
    logic         data_rdy;
    logic         noc_val;
    logic [W-1:0] noc_data;
    logic         noc_rdy;
    logic         len_err;

    int vectors;
    int miscompares;
    int noc_hs_cnt;
    int drdy_cnt;
    bit bp;
    bit tog;

    udp_tx_noc_framer #(.SRC_X(1), .SRC_Y(2), .DST_X(3), .DST_Y(4)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .src_framer_meta_val      (meta_val),
        .src_framer_meta_src_ip   (meta_src_ip),
        .src_framer_meta_dst_ip   (meta_dst_ip),
        .src_framer_meta_src_port (meta_src_port),
        .src_framer_meta_dst_port (meta_dst_port),
        .src_framer_meta_data_len (meta_len),
        .framer_src_meta_rdy      (meta_rdy),
        .src_framer_data_val      (data_val),
        .src_framer_data          (data),
        .src_framer_data_last     (data_last),
        .framer_src_data_rdy      (data_rdy),
        .framer_noc_val           (noc_val),
        .framer_noc_data          (noc_data),
        .noc_framer_rdy           (noc_rdy),
        .framer_len_err           (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count NoC handshakes and data-ready cycles for loss/duplication checks
    always @(posedge clk) begin
        if (noc_val && noc_rdy) noc_hs_cnt <= noc_hs_cnt + 1;
        if (data_rdy) drdy_cnt <= drdy_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_meta(input logic [15:0] len, input logic [31:0] sip, input logic [31:0] dip,
                             input logic [15:0] sp, input logic [15:0] dp);
        meta_val = 1'b1; meta_len = len; meta_src_ip = sip; meta_dst_ip = dip;
        meta_src_port = sp; meta_dst_port = dp;
        for (int i = 0; i < 20 && !meta_rdy; i++) step();
        chk("meta_rdy_before_capture", 32'(meta_rdy), 32'd1);
        step();
        meta_val = 1'b0; meta_len = ~len; meta_src_ip = ~sip; meta_dst_ip = ~dip;
        meta_src_port = ~sp; meta_dst_port = ~dp;
        #1;
        chk("hdr_valid_after_capture", 32'(noc_val), 32'd1);
        chk("meta_rdy_low_after_capture", 32'(meta_rdy), 32'd0);
    endtask

    task automatic take_flit(input string tag, output logic [W-1:0] f);
        logic [W-1:0] held;
        bit have_held;
        bit got;
        have_held = 1'b0;
        got = 1'b0;
        f = '0;
        held = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bp) begin noc_rdy = tog; tog = ~tog; end else noc_rdy = 1'b1;
            #1;
            if (have_held) chkw({tag, "_stable"}, noc_data, held);
            if (noc_val && noc_rdy) begin
                f = noc_data;
                got = 1'b1;
            end else if (noc_val) begin
                held = noc_data;
                have_held = 1'b1;
            end
            chk({tag, "_data_rdy_low"}, 32'(data_rdy), 32'd0);
            step();
        end
        chk({tag, "_taken"}, 32'(got), 32'd1);
    endtask

    task automatic push_data(input string tag, input logic [W-1:0] d, input bit last, input bit check_pass);
        bit got;
        got = 1'b0;
        data_val = 1'b1; data = d; data_last = last;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bp) begin noc_rdy = tog; tog = ~tog; end else noc_rdy = 1'b1;
            #1;
            if (data_rdy) begin
                if (check_pass) chkw({tag, "_pass"}, noc_data, d);
                got = 1'b1;
            end
            step();
        end
        data_val = 1'b0; data_last = 1'b0;
        if (check_pass || !got) chk({tag, "_taken"}, 32'(got), 32'd1);
    endtask

    task automatic check_hdr(input string tag, input logic [W-1:0] f, input logic [21:0] exp_len, input bit full);
        noc_hdr_flit h;
        h = f;
        chk({tag, "_msg_len"}, 32'(h.msg_len), 32'(exp_len));
        if (full) begin
            chk({tag, "_msg_type"}, 32'(h.msg_type), 32'd40);
            chk({tag, "_dst_x"}, 32'(h.dst_x), 32'd3);
            chk({tag, "_dst_y"}, 32'(h.dst_y), 32'd4);
            chk({tag, "_src_x"}, 32'(h.src_x), 32'd1);
            chk({tag, "_src_y"}, 32'(h.src_y), 32'd2);
            chk({tag, "_pad_zero"}, 32'(h.metadata == '0), 32'd1);
        end
    endtask

    task automatic check_meta(input string tag, input logic [W-1:0] f, input logic [15:0] len,
                              input logic [31:0] sip, input logic [31:0] dip,
                              input logic [15:0] sp, input logic [15:0] dp);
        udp_tx_metadata_flit m;
        m = f;
        chk({tag, "_data_len"}, 32'(m.data_len), 32'(len));
        chk({tag, "_src_ip"}, m.src_ip, sip);
        chk({tag, "_dst_ip"}, m.dst_ip, dip);
        chk({tag, "_src_port"}, 32'(m.src_port), 32'(sp));
        chk({tag, "_dst_port"}, 32'(m.dst_port), 32'(dp));
        chk({tag, "_pad_zero"}, 32'(m.padding == '0), 32'd1);
    endtask

    initial begin
        logic [W-1:0] f;
        logic [W-1:0] pat;
        int hs0;
        int dr0;
        vectors = 0; miscompares = 0; noc_hs_cnt = 0; drdy_cnt = 0;
        bp = 1'b0; tog = 1'b0;
        rst_n = 1'b0; meta_val = 1'b0; meta_src_ip = 32'd0; meta_dst_ip = 32'd0;
        meta_src_port = 16'd0; meta_dst_port = 16'd0; meta_len = 16'd0;
        data_val = 1'b0; data = '0; data_last = 1'b0; noc_rdy = 1'b1;

        // reset state
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rst_noc_val", 32'(noc_val), 32'd0);
        chk("rst_meta_rdy", 32'(meta_rdy), 32'd1);
        chk("rst_data_rdy", 32'(data_rdy), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);

        // normal packet: 100 bytes -> 2 data flits, msg_len 3
        hs0 = noc_hs_cnt;
        send_meta(16'd100, 32'hC0A8_0001, 32'h0A00_0002, 16'd1234, 16'd5678);
        take_flit("p1_hdr", f);
        check_hdr("p1_hdr", f, 22'd3, 1'b1);
        take_flit("p1_meta", f);
        check_meta("p1_meta", f, 16'd100, 32'hC0A8_0001, 32'h0A00_0002, 16'd1234, 16'd5678);
        pat = {16{32'hA5A5_0001}};
        push_data("p1_d0", pat, 1'b0, 1'b1);
        pat = {16{32'h5A5A_0002}};
        push_data("p1_d1", pat, 1'b1, 1'b1);
        chk("p1_flit_count", 32'(noc_hs_cnt - hs0), 32'd4);
        chk("p1_back_ready", 32'(meta_rdy), 32'd1);
        chk("p1_len_err", 32'(len_err), 32'd0);

        // zero payload: header, metadata, straight back to READY
        hs0 = noc_hs_cnt; dr0 = drdy_cnt;
        send_meta(16'd0, 32'h0102_0304, 32'h0506_0708, 16'd1, 16'd2);
        take_flit("p2_hdr", f);
        check_hdr("p2_hdr", f, 22'd1, 1'b0);
        take_flit("p2_meta", f);
        check_meta("p2_meta", f, 16'd0, 32'h0102_0304, 32'h0506_0708, 16'd1, 16'd2);
        chk("p2_back_ready", 32'(meta_rdy), 32'd1);
        step();
        chk("p2_flit_count", 32'(noc_hs_cnt - hs0), 32'd2);
        chk("p2_data_rdy_never", 32'(drdy_cnt - dr0), 32'd0);

        // backpressure: ready toggles 0101.., each flit held until accepted
        hs0 = noc_hs_cnt;
        bp = 1'b1; tog = 1'b0;
        send_meta(16'd100, 32'hDEAD_BEEF, 32'hFEED_F00D, 16'd80, 16'd8080);
        take_flit("p3_hdr", f);
        check_hdr("p3_hdr", f, 22'd3, 1'b0);
        take_flit("p3_meta", f);
        check_meta("p3_meta", f, 16'd100, 32'hDEAD_BEEF, 32'hFEED_F00D, 16'd80, 16'd8080);
        pat = {16{32'h1111_2222}};
        push_data("p3_d0", pat, 1'b0, 1'b1);
        pat = {16{32'h3333_4444}};
        push_data("p3_d1", pat, 1'b1, 1'b1);
        bp = 1'b0; noc_rdy = 1'b1;
        chk("p3_flit_count", 32'(noc_hs_cnt - hs0), 32'd4);
        chk("p3_back_ready", 32'(meta_rdy), 32'd1);

        // length mismatch: 64 bytes is one flit, but last is not asserted
        send_meta(16'd64, 32'h1, 32'h2, 16'd3, 16'd4);
        take_flit("p4_hdr", f);
        check_hdr("p4_hdr", f, 22'd2, 1'b0);
        take_flit("p4_meta", f);
        pat = {16{32'h7777_0000}};
        push_data("p4_d0", pat, 1'b0, 1'b1);
        chk("p4_len_err_set", 32'(len_err), 32'd1);
        chk("p4_back_ready", 32'(meta_rdy), 32'd1);
        send_meta(16'd0, 32'h5, 32'h6, 16'd7, 16'd8);
        take_flit("p4b_hdr", f);
        take_flit("p4b_meta", f);
        chk("p4_len_err_sticky", 32'(len_err), 32'd1);

        // boundary: 65535 bytes -> 1024 data flits, msg_len 1025
        hs0 = noc_hs_cnt;
        send_meta(16'hFFFF, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 16'hFFFF, 16'h0000);
        take_flit("p5_hdr", f);
        check_hdr("p5_hdr", f, 22'd1025, 1'b0);
        take_flit("p5_meta", f);
        check_meta("p5_meta", f, 16'hFFFF, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 16'hFFFF, 16'h0000);
        for (int i = 0; i < 1023; i++) begin
            pat = W'(i);
            push_data("p5_d", pat, 1'b0, 1'b0);
        end
        chk("p5_still_data", 32'(data_rdy), 32'd1);
        pat = W'(1023);
        push_data("p5_dlast", pat, 1'b1, 1'b1);
        chk("p5_flit_count", 32'(noc_hs_cnt - hs0), 32'd1026);
        chk("p5_back_ready", 32'(meta_rdy), 32'd1);

        // reset in the middle of a 3-flit payload
        send_meta(16'd150, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 16'd11, 16'd22);
        take_flit("p6_hdr", f);
        check_hdr("p6_hdr", f, 22'd4, 1'b0);
        take_flit("p6_meta", f);
        pat = {16{32'hCAFE_0001}};
        push_data("p6_d0", pat, 1'b0, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        data_val = 1'b1; data = {16{32'hCAFE_0002}};
        #1;
        chk("p6_rst_noc_val", 32'(noc_val), 32'd0);
        chk("p6_rst_meta_rdy", 32'(meta_rdy), 32'd1);
        chk("p6_rst_data_rdy", 32'(data_rdy), 32'd0);
        chk("p6_rst_len_err", 32'(len_err), 32'd0);
        data_val = 1'b0;
        hs0 = noc_hs_cnt;
        send_meta(16'd64, 32'h0C0C_0C0C, 32'h0D0D_0D0D, 16'd33, 16'd44);
        take_flit("p7_hdr", f);
        check_hdr("p7_hdr", f, 22'd2, 1'b0);
        take_flit("p7_meta", f);
        check_meta("p7_meta", f, 16'd64, 32'h0C0C_0C0C, 32'h0D0D_0D0D, 16'd33, 16'd44);
        pat = {16{32'hBEEF_0007}};
        push_data("p7_d0", pat, 1'b1, 1'b1);
        chk("p7_flit_count", 32'(noc_hs_cnt - hs0), 32'd3);
        chk("p7_len_err", 32'(len_err), 32'd0);
        chk("p7_back_ready", 32'(meta_rdy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/udp_tx_noc_framer.md
UDP_TX_NOC_FRAMER -- requirements
Module: udp_tx_noc_framer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SRC_X  0  NoC X coordinate of this tile
  SRC_Y  0  NoC Y coordinate of this tile
  DST_X  0  NoC X coordinate of the UDP TX engine
  DST_Y  0  NoC Y coordinate of the UDP TX engine
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  the single clock
  rst_n  in  1  synchronous, active-low reset
  src_framer_meta_val  in  1  metadata valid
  src_framer_meta_src_ip  in  32  source IPv4 address
  src_framer_meta_dst_ip  in  32  destination IPv4 address
  src_framer_meta_src_port  in  16  source UDP port
  src_framer_meta_dst_port  in  16  destination UDP port
  src_framer_meta_data_len  in  16  payload length in bytes
  framer_src_meta_rdy  out  1  metadata ready
  src_framer_data_val  in  1  payload flit valid
  src_framer_data  in  `NOC_DATA_WIDTH  payload flit
  src_framer_data_last  in  1  final payload flit marker
  framer_src_data_rdy  out  1  payload ready
  framer_noc_val  out  1  NoC flit valid
  framer_noc_data  out  `NOC_DATA_WIDTH  NoC flit
  noc_framer_rdy  in  1  NoC ready
  framer_len_err  out  1  sticky: data_last did not match computed length

Function
REQ-003 A transfer on any interface SHALL occur only in a cycle where val and rdy are both 1.
REQ-004 The FSM SHALL have four states, with these transitions:
  READY: meta_rdy=1; on a meta handshake, register all fields -> HDR.
  HDR: emit header flit; on NoC handshake -> META.
  META: emit the udp_tx_metadata_flit; on handshake -> DATA, or -> READY if data_len=0.
  DATA: pass payload through; on the handshake of the final flit -> READY.
REQ-005 Every field SHALL be captured on the meta handshake, and the first header flit SHALL be valid in the cycle after capture.
REQ-006 Flit math: num_data_flits = ceil(data_len / (`NOC_DATA_WIDTH/8)), computed in 17-bit arithmetic so that data_len=16'hFFFF does not overflow.
REQ-007 The header flit SHALL be a tcp_noc_hdr_flit-style NoC header with these fields:
  dst_x/y = DST_X/Y, src_x/y = SRC_X/Y
  msg_len = 1 + num_data_flits
  msg_type = UDP TX segment
  unused bits = 0
REQ-008 The metadata flit SHALL carry the registered IPs, ports and data_len, with padding bits 0, and SHALL be exactly `NOC_DATA_WIDTH wide.
REQ-009 In DATA, the following SHALL hold combinationally:
  framer_noc_val = src_framer_data_val
  framer_noc_data = src_framer_data
  framer_src_data_rdy = noc_framer_rdy
REQ-010 In DATA, a down-counter loaded with num_data_flits SHALL decrement on each handshake, and the handshake with counter=1 SHALL be the final flit.
REQ-011 The flit count SHALL be authoritative: if data_last differs from (counter=1) on a handshake, framer_len_err SHALL set and hold until reset, while the framing continues by count.
REQ-012 framer_src_data_rdy SHALL be 0 outside DATA, and framer_src_meta_rdy SHALL be 0 outside READY.
REQ-013 framer_noc_val SHALL be 1 in HDR and META regardless of downstream ready, and framer_noc_data SHALL stay stable while val=1 and rdy=0.
REQ-014 The final-flit handshake in DATA SHALL return to READY, with no meta accepted in that same cycle, giving a minimum gap of one cycle between packets.

Reset
REQ-015 While rst_n=0 at a clk edge, the state SHALL become READY, the counter and registered fields 0, and framer_len_err 0.
REQ-016 After reset, the outputs SHALL be framer_noc_val=0, framer_src_data_rdy=0, framer_src_meta_rdy=1.
REQ-017 Reset asserted mid-packet SHALL abandon the packet without emitting further flits.

Structure
REQ-018 The following SHALL reside in the shared beehive_udp_msg package:
  udp_tx_metadata_flit
  the UDP TX msg_type constant
  the flit-count function
REQ-019 The header flit type SHALL come from the existing NoC message package, and its width SHALL be checked by the parameter-checking block.
REQ-020 The block SHALL be a single module with no sub-modules, and the FSM and datapath SHALL sit in separate always blocks.

Verification
REQ-021 Normal packet: data_len=100, noc_rdy=1 -> the bench SHALL see 4 flits (header msg_len=3, meta, 2 data), a second flit with data_len=100, and err=0.
REQ-022 Zero payload: data_len=0 -> the bench SHALL see header msg_len=1, then meta, then READY, with data_rdy never asserting.
REQ-023 Backpressure: noc_rdy toggling 1010… -> each flit SHALL be held stable until accepted, with no loss and no duplication.
REQ-024 Length mismatch: data_len=64 with data_last=0 on the sole flit -> err=1 after that handshake, state READY, and err still 1 after the next packet.
REQ-025 Boundary: data_len=65535 -> msg_len=1025, with exactly 1024 data flits accepted.
REQ-026 Reset mid-DATA: rst_n=0 for one cycle after 1 of 3 data flits -> next cycle val=0 and meta_rdy=1, after which a new packet frames correctly.
